// File: rtl/instr_reg_sched.sv
// Round-robin write scheduler and FIFO sequencer for the instruction register.
// Grants one requester per cycle, issues a one-cycle-delayed load and tracks FIFO read order.
module instr_reg_sched #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DEPTH   = 32,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*4-1:0]       req_opcode,
    input  logic [NUM_REQ*32-1:0]      req_operand_a,
    input  logic [NUM_REQ*32-1:0]      req_operand_b,
    output logic                       load_en,
    output logic [3:0]                 opcode,
    output logic [31:0]                operand_a,
    output logic [31:0]                operand_b,
    output logic [$clog2(DEPTH)-1:0]   write_pointer,
    output logic [$clog2(DEPTH)-1:0]   read_pointer,
    output logic                       rd_valid,
    input  logic                       rd_ready,
    output logic [ID_W-1:0]            rd_src,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef logic [3:0]    opcode_t;
    typedef logic [31:0]   operand_t;
    typedef logic [AW-1:0] address_t;

    // Per-requester views of the packed request buses
    opcode_t  req_op_arr [NUM_REQ];
    operand_t req_a_arr  [NUM_REQ];
    operand_t req_b_arr  [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign req_op_arr[g] = req_opcode[g*4 +: 4];
        assign req_a_arr[g]  = req_operand_a[g*32 +: 32];
        assign req_b_arr[g]  = req_operand_b[g*32 +: 32];
    end

    // State registers
    logic [ID_W-1:0] prio_q, prio_d;
    logic            load_en_q, load_en_d;
    opcode_t         opcode_q, opcode_d;
    operand_t        operand_a_q, operand_a_d;
    operand_t        operand_b_q, operand_b_d;
    address_t        write_pointer_q, write_pointer_d;
    address_t        wr_ptr_q, wr_ptr_d;
    address_t        read_pointer_q, read_pointer_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   committed_q, committed_d;
    logic [ID_W-1:0] src_tbl_q [DEPTH];

    // Arbitration signals
    logic            gnt_found;
    logic [ID_W-1:0] gnt_idx;
    logic [ID_W:0]   scan_sum;
    logic            accept;
    logic            pop;
    logic            full_w;
    logic            rd_valid_w;

    assign full_w     = (count_q == CW'(DEPTH));
    assign rd_valid_w = (committed_q != '0);
    assign pop        = rd_valid_w & rd_ready;

    // Scan from the priority pointer, wrapping modulo NUM_REQ
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        scan_sum  = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            scan_sum = {1'b0, prio_q} + (ID_W+1)'(k);
            if (scan_sum >= (ID_W+1)'(NUM_REQ)) begin
                scan_sum = scan_sum - (ID_W+1)'(NUM_REQ);
            end
            if (!gnt_found && req_valid[scan_sum[ID_W-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = scan_sum[ID_W-1:0];
            end
        end
    end

    assign accept = gnt_found & ~full_w;

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        prio_d          = prio_q;
        load_en_d       = accept;
        opcode_d        = opcode_q;
        operand_a_d     = operand_a_q;
        operand_b_d     = operand_b_q;
        write_pointer_d = write_pointer_q;
        wr_ptr_d        = wr_ptr_q;
        read_pointer_d  = read_pointer_q;
        count_d         = count_q;
        committed_d     = committed_q;

        if (accept) begin
            prio_d          = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
            opcode_d        = req_op_arr[gnt_idx];
            operand_a_d     = req_a_arr[gnt_idx];
            operand_b_d     = req_b_arr[gnt_idx];
            write_pointer_d = wr_ptr_q;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end

        if (pop) begin
            read_pointer_d = read_pointer_q + 1'b1;
        end

        // count reserves space at acceptance; committed only once the register write lands
        case ({accept, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        case ({load_en_q, pop})
            2'b10:   committed_d = committed_q + 1'b1;
            2'b01:   committed_d = committed_q - 1'b1;
            default: committed_d = committed_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prio_q          <= '0;
            load_en_q       <= 1'b0;
            opcode_q        <= '0;
            operand_a_q     <= '0;
            operand_b_q     <= '0;
            write_pointer_q <= '0;
            wr_ptr_q        <= '0;
            read_pointer_q  <= '0;
            count_q         <= '0;
            committed_q     <= '0;
        end else begin
            prio_q          <= prio_d;
            load_en_q       <= load_en_d;
            opcode_q        <= opcode_d;
            operand_a_q     <= operand_a_d;
            operand_b_q     <= operand_b_d;
            write_pointer_q <= write_pointer_d;
            wr_ptr_q        <= wr_ptr_d;
            read_pointer_q  <= read_pointer_d;
            count_q         <= count_d;
            committed_q     <= committed_d;
        end
    end

    // Side table of writer IDs, cleared on reset so rd_src reads 0 afterwards
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                src_tbl_q[i] <= '0;
            end
        end else if (accept) begin
            src_tbl_q[wr_ptr_q] <= gnt_idx;
        end
    end

    assign load_en       = load_en_q;
    assign opcode        = opcode_q;
    assign operand_a     = operand_a_q;
    assign operand_b     = operand_b_q;
    assign write_pointer = write_pointer_q;
    assign read_pointer  = read_pointer_q;
    assign rd_valid      = rd_valid_w;
    assign rd_src        = src_tbl_q[read_pointer_q];
    assign count         = count_q;
    assign full          = full_w;

    a_ready_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(req_ready));
    a_count_bound:  assert property (@(posedge clk) disable iff (reset) count_q <= CW'(DEPTH));
    a_committed_le: assert property (@(posedge clk) disable iff (reset) committed_q <= count_q);

endmodule

// File: tb/tb_instr_reg_sched.sv
// Directed bench for instr_reg_sched: vector table plus hand-written corner sequences.
module tb_instr_reg_sched;

    localparam int NR    = 4;
    localparam int DEPTH = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic [3:0]    req_valid;
    logic [3:0]    req_ready;
    logic [15:0]   req_opcode;
    logic [127:0]  req_operand_a;
    logic [127:0]  req_operand_b;
    logic          load_en;
    logic [3:0]    opcode;
    logic [31:0]   operand_a;
    logic [31:0]   operand_b;
    logic [4:0]    write_pointer;
    logic [4:0]    read_pointer;
    logic          rd_valid;
    logic          rd_ready;
    logic [1:0]    rd_src;
    logic [5:0]    count;
    logic          full;

    instr_reg_sched #(.NUM_REQ(NR), .DEPTH(DEPTH), .ID_W(2)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_opcode    (req_opcode),
        .req_operand_a (req_operand_a),
        .req_operand_b (req_operand_b),
        .load_en       (load_en),
        .opcode        (opcode),
        .operand_a     (operand_a),
        .operand_b     (operand_b),
        .write_pointer (write_pointer),
        .read_pointer  (read_pointer),
        .rd_valid      (rd_valid),
        .rd_ready      (rd_ready),
        .rd_src        (rd_src),
        .count         (count),
        .full          (full)
    );

    always #5 clk = ~clk;

    // External instruction register model: {opcode, operand_a, operand_b}
    logic [67:0] mem [DEPTH];
    always @(posedge clk) begin
        if (load_en) mem[write_pointer] <= {opcode, operand_a, operand_b};
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic set_defaults();
        req_valid     = '0;
        rd_ready      = 1'b0;
        req_opcode    = 16'h5432;
        req_operand_a = {32'h103, 32'h102, 32'h101, 32'h100};
        req_operand_b = {32'h203, 32'h202, 32'h201, 32'h200};
    endtask

    task automatic do_reset();
        @(negedge clk);
        set_defaults();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    typedef struct packed {
        logic [3:0] valid;
        logic       rd;
        logic [3:0] ready;
        logic       le;
        logic [4:0] wp;
        logic [5:0] cnt;
        logic       rv;
        logic [4:0] rp;
        logic [1:0] src;
    } vec_t;

    vec_t tbl [12];

    typedef struct {
        logic [1:0]  src;
        logic [31:0] a;
    } sb_t;
    sb_t sbq [$];

    initial begin
        logic [67:0] e;
        sb_t         x;
        int          pops;

        // valid, rd_ready, exp ready, load_en, wp, count, rd_valid, rp, rd_src
        tbl[0]  = '{4'b1111, 1'b0, 4'b0001, 1'b1, 5'd0, 6'd1, 1'b0, 5'd0, 2'd0};
        tbl[1]  = '{4'b1111, 1'b0, 4'b0010, 1'b1, 5'd1, 6'd2, 1'b1, 5'd0, 2'd0};
        tbl[2]  = '{4'b1111, 1'b0, 4'b0100, 1'b1, 5'd2, 6'd3, 1'b1, 5'd0, 2'd0};
        tbl[3]  = '{4'b1111, 1'b0, 4'b1000, 1'b1, 5'd3, 6'd4, 1'b1, 5'd0, 2'd0};
        tbl[4]  = '{4'b0010, 1'b0, 4'b0010, 1'b1, 5'd4, 6'd5, 1'b1, 5'd0, 2'd0};
        tbl[5]  = '{4'b0011, 1'b0, 4'b0001, 1'b1, 5'd5, 6'd6, 1'b1, 5'd0, 2'd0};
        tbl[6]  = '{4'b0011, 1'b0, 4'b0010, 1'b1, 5'd6, 6'd7, 1'b1, 5'd0, 2'd0};
        tbl[7]  = '{4'b1000, 1'b0, 4'b1000, 1'b1, 5'd7, 6'd8, 1'b1, 5'd0, 2'd0};
        tbl[8]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 5'd7, 6'd7, 1'b1, 5'd1, 2'd1};
        tbl[9]  = '{4'b0110, 1'b1, 4'b0010, 1'b1, 5'd8, 6'd7, 1'b1, 5'd2, 2'd2};
        tbl[10] = '{4'b0110, 1'b0, 4'b0100, 1'b1, 5'd9, 6'd8, 1'b1, 5'd2, 2'd2};
        tbl[11] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 5'd9, 6'd8, 1'b1, 5'd2, 2'd2};

        reset = 1'b1;
        set_defaults();
        do_reset();

        chk("rst_load_en", load_en, 1'b0);
        chk("rst_count", count, 6'd0);
        chk("rst_rd_valid", rd_valid, 1'b0);
        chk("rst_full", full, 1'b0);
        chk("rst_wp", write_pointer, 5'd0);
        chk("rst_rp", read_pointer, 5'd0);
        chk("rst_rd_src", rd_src, 2'd0);
        chk("rst_opcode", opcode, 4'd0);
        chk("rst_ready", req_ready, 4'b0000);

        // Table: round-robin order, priority wrap and interleaved pops
        foreach (tbl[i]) begin
            @(negedge clk);
            req_valid = tbl[i].valid;
            rd_ready  = tbl[i].rd;
            #1;
            chk($sformatf("v%0d_ready", i), req_ready, tbl[i].ready);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_load_en", i), load_en, tbl[i].le);
            chk($sformatf("v%0d_wp", i), write_pointer, tbl[i].wp);
            chk($sformatf("v%0d_count", i), count, tbl[i].cnt);
            chk($sformatf("v%0d_rd_valid", i), rd_valid, tbl[i].rv);
            chk($sformatf("v%0d_rp", i), read_pointer, tbl[i].rp);
            chk($sformatf("v%0d_rd_src", i), rd_src, tbl[i].src);
        end

        // Single PASSA from requester 1 through to consumer pop
        do_reset();
        @(negedge clk);
        req_opcode[7:4]      = 4'h1;
        req_operand_a[63:32] = 32'd5;
        req_operand_b[63:32] = 32'd9;
        req_valid            = 4'b0010;
        #1;
        chk("pa_ready", req_ready, 4'b0010);
        @(posedge clk);
        #1;
        chk("pa_load_en", load_en, 1'b1);
        chk("pa_opcode", opcode, 4'h1);
        chk("pa_a", operand_a, 32'd5);
        chk("pa_b", operand_b, 32'd9);
        chk("pa_wp", write_pointer, 5'd0);
        chk("pa_rv_early", rd_valid, 1'b0);
        @(negedge clk);
        req_valid = '0;
        @(posedge clk);
        #1;
        chk("pa_load_en_low", load_en, 1'b0);
        chk("pa_opcode_hold", opcode, 4'h1);
        chk("pa_rv", rd_valid, 1'b1);
        chk("pa_rp", read_pointer, 5'd0);
        chk("pa_rd_src", rd_src, 2'd1);
        e = mem[0];
        chk("pa_result", e[63:32], 32'd5);
        @(negedge clk);
        rd_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("pa_pop_rv", rd_valid, 1'b0);
        chk("pa_pop_rp", read_pointer, 5'd1);
        chk("pa_pop_count", count, 6'd0);
        @(posedge clk);
        #1;
        chk("pa_idle_rp", read_pointer, 5'd1);
        chk("pa_idle_count", count, 6'd0);
        rd_ready = 1'b0;

        // Fill to full, then a single pop frees one slot
        do_reset();
        for (int c = 0; c < DEPTH; c++) begin
            @(negedge clk);
            req_valid = 4'b0001;
            #1;
            chk($sformatf("fill%0d_ready", c), req_ready, 4'b0001);
            @(posedge clk);
            #1;
        end
        chk("full_count", count, 6'd32);
        chk("full_flag", full, 1'b1);
        chk("full_wp", write_pointer, 5'd31);
        @(negedge clk);
        rd_ready = 1'b1;
        #1;
        chk("full_ready_blocked", req_ready, 4'b0000);
        @(posedge clk);
        #1;
        chk("full_pop_rp", read_pointer, 5'd1);
        chk("full_pop_count", count, 6'd31);
        chk("full_pop_flag", full, 1'b0);
        @(negedge clk);
        rd_ready = 1'b0;
        #1;
        chk("full_resume_ready", req_ready, 4'b0001);
        @(posedge clk);
        #1;
        chk("full_wrap_wp", write_pointer, 5'd0);
        chk("full_refill_count", count, 6'd32);
        chk("full_refill_flag", full, 1'b1);

        // Steady state: one request and one pop per cycle
        do_reset();
        pops = 0;
        sbq.delete();
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            req_valid     = 4'b0001 << (c % 4);
            req_operand_a = {4{32'(c)}};
            rd_ready      = 1'b1;
            #1;
            chk($sformatf("ss%0d_ready", c), req_ready, 4'b0001 << (c % 4));
            x.src = 2'(c % 4);
            x.a   = 32'(c);
            sbq.push_back(x);
            chk($sformatf("ss%0d_rv", c), rd_valid, (c >= 2) ? 1'b1 : 1'b0);
            if (c >= 2 && sbq.size() > 0) begin
                x = sbq.pop_front();
                e = mem[read_pointer];
                chk($sformatf("ss%0d_src", c), rd_src, x.src);
                chk($sformatf("ss%0d_a", c), e[63:32], x.a);
                pops++;
            end
            @(posedge clk);
            #1;
            chk($sformatf("ss%0d_count", c), count, (c == 0) ? 6'd1 : 6'd2);
        end
        chk("ss_pops", pops, 98);
        chk("ss_final_rp", read_pointer, 5'd2);
        chk("ss_final_wp", write_pointer, 5'd3);
        @(negedge clk);
        req_valid = '0;
        rd_ready  = 1'b0;

        // Reset one cycle after an acceptance drops the in-flight load
        do_reset();
        @(negedge clk);
        req_valid = 4'b1111;
        #1;
        chk("ra_ready", req_ready, 4'b0001);
        @(posedge clk);
        #1;
        chk("ra_load_en_pre", load_en, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("ra_load_en", load_en, 1'b0);
        chk("ra_count", count, 6'd0);
        chk("ra_rd_valid", rd_valid, 1'b0);
        chk("ra_wp", write_pointer, 5'd0);
        chk("ra_rp", read_pointer, 5'd0);
        chk("ra_opcode", opcode, 4'd0);
        @(negedge clk);
        #1;
        chk("ra_restart_ready", req_ready, 4'b0001);
        @(posedge clk);
        #1;
        chk("ra_restart_count", count, 6'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
